// File: rtl/iob_rom_mp.sv
// Multi-port synchronous ROM: N_PORTS requesters share one array through a round-robin
// req/ack arbiter. Optional macro IOB_ROM_MP_OUT_REG_EN adds a second output stage (latency 2).
module iob_rom_mp #(
  parameter int    DATA_W  = 8,
  parameter int    ADDR_W  = 4,
  parameter int    N_PORTS = 2,
  parameter string HEXFILE = "none"
) (
  input  logic                        clk,
  input  logic                        arst_n,
  input  logic [N_PORTS-1:0]          req,
  input  logic [N_PORTS*ADDR_W-1:0]   addr,
  output logic [N_PORTS-1:0]          ack,
  output logic [N_PORTS-1:0]          r_valid,
  output logic [N_PORTS*DATA_W-1:0]   r_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] rom [0:DEPTH-1];

  // Handshake: a read transfers on the rising edge where req[i] && ack[i]; the requester
  // holds req[i]/addr slice i stable until then and may keep req high for back-to-back reads.
  logic [3:0]          ptr_q, ptr_d;
  logic [N_PORTS-1:0]  gnt;
  logic                gnt_any;
  logic [3:0]          gnt_idx;
  logic                found_hi;
  logic [3:0]          idx_hi, idx_lo;
  logic [ADDR_W-1:0]   gnt_addr;
  logic [DATA_W-1:0]   rd_word;

  // First requester at or above ptr wins; otherwise the lowest requester (wrap-around).
  always_comb begin
    found_hi = 1'b0;
    idx_hi   = '0;
    gnt_any  = 1'b0;
    idx_lo   = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (!found_hi && req[i] && (4'(i) >= ptr_q)) begin
        found_hi = 1'b1;
        idx_hi   = 4'(i);
      end
    end
    for (int i = 0; i < N_PORTS; i++) begin
      if (!gnt_any && req[i]) begin
        gnt_any = 1'b1;
        idx_lo  = 4'(i);
      end
    end
    gnt_idx = found_hi ? idx_hi : idx_lo;
    if (!arst_n) gnt_any = 1'b0;
  end

  always_comb begin
    gnt      = '0;
    gnt_addr = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      gnt[i] = gnt_any && (gnt_idx == 4'(i));
      if (gnt[i]) gnt_addr = addr[i*ADDR_W +: ADDR_W];
    end
    rd_word = rom[gnt_addr];
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) ptr_d = (gnt_idx == 4'(N_PORTS - 1)) ? 4'd0 : gnt_idx + 4'd1;
  end

  assign ack = gnt;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

  logic [N_PORTS-1:0] out_vld;
  logic [DATA_W-1:0]  out_word;

`ifdef IOB_ROM_MP_OUT_REG_EN
  // Array read is captured into a shared word plus the grant vector, then fanned out a cycle later.
  logic [N_PORTS-1:0] s1_valid_q;
  logic [DATA_W-1:0]  s1_data_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      s1_valid_q <= '0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= gnt;
      if (gnt_any) s1_data_q <= rd_word;
    end
  end

  assign out_vld  = s1_valid_q;
  assign out_word = s1_data_q;
`else
  assign out_vld  = gnt;
  assign out_word = rd_word;
`endif

  logic [N_PORTS-1:0]        r_valid_q;
  logic [N_PORTS*DATA_W-1:0] r_data_q;

  // Only the slice of the port being served is written; every other slice holds.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_valid_q <= '0;
      r_data_q  <= '0;
    end else begin
      r_valid_q <= out_vld;
      for (int i = 0; i < N_PORTS; i++) begin
        if (out_vld[i]) r_data_q[i*DATA_W +: DATA_W] <= out_word;
      end
    end
  end

  assign r_valid = r_valid_q;
  assign r_data  = r_data_q;

endmodule

// File: tb/tb_iob_rom_mp.sv
// Bench for iob_rom_mp (4 ports, 8-bit data, 16 words). Model: rotating-priority arbiter
// plus an in-flight queue of expected read results delayed by the build's latency.
module tb_iob_rom_mp;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int NP = 4;
`ifdef IOB_ROM_MP_OUT_REG_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif

  logic              clk = 1'b0;
  logic              arst_n = 1'b0;
  logic [NP-1:0]     req = '0;
  logic [NP*AW-1:0]  addr = '0;
  logic [NP-1:0]     ack;
  logic [NP-1:0]     r_valid;
  logic [NP*DW-1:0]  r_data;

  iob_rom_mp #(.DATA_W(DW), .ADDR_W(AW), .N_PORTS(NP), .HEXFILE("none")) dut (
    .clk(clk), .arst_n(arst_n), .req(req), .addr(addr),
    .ack(ack), .r_valid(r_valid), .r_data(r_data)
  );

  // clock/reset block
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int mptr;
  int last_gnt;
  int acnt [NP];
  logic [DW-1:0] exp_rdata [NP];
  logic [NP-1:0] exp_vld;
  // in-flight reads: bit 12 valid, [11:8] port, [7:0] data
  logic [12:0] exp_q [$];

  function automatic int model_rom(int a);
    return a + 32;
  endfunction

  function automatic int arb(logic [NP-1:0] r);
    for (int off = 0; off < NP; off++) begin
      if (r[(mptr + off) % NP]) return (mptr + off) % NP;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mptr = 0;
    exp_q.delete();
    for (int i = 0; i < L - 1; i++) exp_q.push_back('0);
    for (int i = 0; i < NP; i++) exp_rdata[i] = '0;
    exp_vld = '0;
  endtask

  task automatic set_addr(input int p, input int a);
    addr[p*AW +: AW] = AW'(a);
  endtask

  // driver: called at negedge with inputs applied; returns at the following negedge
  task automatic cycle();
    logic [12:0]   e;
    logic [NP-1:0] exp_ack;
    int            g;
    #1;
    g = arb(req);
    exp_ack = '0;
    if (g >= 0) exp_ack[g] = 1'b1;
    chk("ack", {60'd0, ack}, {60'd0, exp_ack});
    last_gnt = g;
    e = '0;
    if (g >= 0) begin
      e[12]   = 1'b1;
      e[11:8] = 4'(g);
      e[7:0]  = 8'(model_rom(int'(addr[g*AW +: AW])));
      mptr    = (g + 1) % NP;
    end
    @(posedge clk);
    exp_q.push_back(e);
    e = exp_q.pop_front();
    exp_vld = '0;
    if (e[12]) begin
      exp_vld[int'(e[11:8])]   = 1'b1;
      exp_rdata[int'(e[11:8])] = e[7:0];
    end
    #1;
    chk("r_valid", {60'd0, r_valid}, {60'd0, exp_vld});
    for (int i = 0; i < NP; i++)
      chk($sformatf("r_data%0d", i), {56'd0, r_data[i*DW +: DW]}, {56'd0, exp_rdata[i]});
    @(negedge clk);
  endtask

  task automatic expect_ack(input string tag, input logic [NP-1:0] v);
    #1;
    chk(tag, {60'd0, ack}, {60'd0, v});
  endtask

  task automatic drain();
    req = '0;
    for (int i = 0; i < L + 1; i++) cycle();
  endtask

  task automatic do_reset();
    req = '0;
    arst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 2 ** AW; i++) dut.rom[i] = DW'(i + 32);
    model_reset();
    @(negedge clk);
    @(negedge clk);

    // reset state
    #1;
    chk("rst_ack", {60'd0, ack}, 64'd0);
    chk("rst_r_valid", {60'd0, r_valid}, 64'd0);
    chk("rst_r_data", {32'd0, r_data}, 64'd0);
    @(negedge clk);
    arst_n = 1'b1;

    // single port sweep
    req = 4'b0001;
    for (int a = 0; a < 16; a++) begin
      set_addr(0, a);
      expect_ack("sweep_ack", 4'b0001);
      cycle();
    end
    drain();
    chk("sweep_last", {56'd0, r_data[7:0]}, 64'h2f);
    chk("sweep_others", {40'd0, r_data[31:8]}, 64'd0);

    // all four continuous from reset
    do_reset();
    for (int p = 0; p < NP; p++) begin
      acnt[p] = $urandom_range(0, 15);
      set_addr(p, acnt[p]);
    end
    req = 4'b1111;
    for (int c = 0; c < 24; c++) begin
      expect_ack("rr_ack", 4'b0001 << (c % 4));
      cycle();
      if (last_gnt >= 0) begin
        acnt[last_gnt] = (acnt[last_gnt] + 1) % 16;
        set_addr(last_gnt, acnt[last_gnt]);
      end
    end
    drain();

    // wrap and pointer
    req = 4'b1000;
    set_addr(3, 15);
    cycle();
    req = 4'b0101;
    set_addr(0, 3);
    set_addr(2, 9);
    expect_ack("wrap_p0_first", 4'b0001);
    cycle();
    req[0] = 1'b0;
    expect_ack("wrap_p2_next", 4'b0100);
    cycle();
    req = 4'b0010;
    set_addr(1, 1);
    cycle();
    req = 4'b0101;
    expect_ack("ptr_p2_first", 4'b0100);
    cycle();
    req[2] = 1'b0;
    cycle();
    drain();
    chk("wrap_data", {56'd0, r_data[31:24]}, 64'h2f);

    // hold behaviour
    req = 4'b0010;
    set_addr(1, 5);
    cycle();
    req = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      set_addr(2, $urandom_range(0, 15));
      cycle();
    end
    drain();
    chk("hold_r1", {56'd0, r_data[15:8]}, 64'h25);

    // reset immediately after a grant edge
    req = 4'b0100;
    set_addr(2, 7);
    expect_ack("pre_rst_ack", 4'b0100);
    @(posedge clk);
    #1;
    arst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_ack", {60'd0, ack}, 64'd0);
    chk("midrst_r_valid", {60'd0, r_valid}, 64'd0);
    chk("midrst_r_data", {32'd0, r_data}, 64'd0);
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    req = '0;
    @(negedge clk);
    chk("post_rst_r_valid", {60'd0, r_valid}, 64'd0);
    req = 4'b0011;
    set_addr(0, 2);
    set_addr(1, 4);
    expect_ack("post_rst_p0_first", 4'b0001);
    cycle();
    req[0] = 1'b0;
    cycle();
    drain();

    // idle
    req = '0;
    for (int c = 0; c < 20; c++) begin
      addr = NP*AW'($urandom);
      cycle();
    end

    // random traffic honouring the handshake
    for (int c = 0; c < 300; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (!req[p] && $urandom_range(0, 2) != 0) begin
          req[p] = 1'b1;
          set_addr(p, $urandom_range(0, 15));
        end
      end
      cycle();
      if (last_gnt >= 0) begin
        if ($urandom_range(0, 1) == 0) req[last_gnt] = 1'b0;
        else set_addr(last_gnt, $urandom_range(0, 15));
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iob_rom_mp.md
# iob_rom_mp

Parametrised multi-port synchronous ROM. N_PORTS requesters share one single-port ROM array through a round-robin arbiter with a req/ack handshake, and each port has its own held read-data register. It generalises the two-port ROM to any port count in a single clock domain. It serves shared constant tables such as coefficients, microcode and boot images without replicating the array.

## Interface
- DATA_W, 8, word width in bits
- ADDR_W, 4, address width; depth = 2**ADDR_W words
- N_PORTS, 2, number of requester ports (1..16)
- HEXFILE, "none", $readmemh init file; "none" leaves the array uninitialised, for bench preload via hierarchical `rom[]`
- clk  in  1  clock, rising edge
- arst_n  in  1  asynchronous active-low reset
- req  in  N_PORTS  per-port read request; port i is bit i
- addr  in  N_PORTS*ADDR_W  port i address at [i*ADDR_W +: ADDR_W]
- ack  out  N_PORTS  one-hot grant, combinational from req and the priority pointer
- r_valid  out  N_PORTS  one-cycle pulse: port i read data updated this cycle
- r_data  out  N_PORTS*DATA_W  port i data at [i*DATA_W +: DATA_W], held between reads

## Operation
- Requester handshake:
  - Requester raises req[i] with addr stable.
  - Transfer occurs on the rising edge where req[i] && ack[i].
  - Requester keeps req and addr stable until acked.
  - Requester may keep req high for back-to-back reads.
- Arbiter:
  - 4-bit priority pointer ptr, reset 0.
  - Grant goes to the first requesting port scanning ptr, ptr+1, … wrapping at N_PORTS.
  - On a grant to port k: ptr <= (k+1) mod N_PORTS.
  - No request: ack = 0, ptr unchanged.
  - At most one ack bit is high per cycle.
- ROM read:
  - The granted address is read from the array on the grant edge.
  - The result is written only into the granted port's r_data slice.
  - Other slices hold their values.
- r_valid[k] pulses exactly once per accepted request, in order.
- N_PORTS=1: ack = req, and a read is issued every cycle req is high.
- Reset (arst_n low, any time):
  - ptr = 0, r_valid = 0, r_data = 0, pipeline valid bits = 0.
  - In-flight reads are discarded and never produce r_valid.
  - The array contents are not affected.
  - ack is 0 while in reset.

## Timing
- Base latency 1: grant edge T, then r_valid[k]=1 and r_data[k] = rom[addr] in cycle T+1, from a register output.
- Throughput: one read per cycle total across all ports, with no bubbles.
- A port continuously requesting against N-1 other continuous requesters is served every N cycles, so worst-case wait is N_PORTS-1 cycles.
- Simultaneous requests in the same cycle resolve by pointer order only; address values have no effect.
- Address wrap: addr = 2**ADDR_W-1 is legal. There is no out-of-range condition.
- A request arriving in the cycle its previous r_valid pulses is arbitrated normally.

## Configuration
- IOB_ROM_MP_OUT_REG_EN defined:
  - An extra output pipeline stage of per-port data and valid registers is added after the array read.
  - Latency becomes 2: grant at T, r_valid/r_data at T+2.
  - Throughput is unchanged.
  - Reset clears both stages.
- IOB_ROM_MP_OUT_REG_EN undefined: latency 1 as above, and the stage is absent.
- ack timing is identical in both builds.

## Test plan
Preload rom[i] = i+32 for DATA_W=8, ADDR_W=4, N_PORTS=4. Expected latency L is 1, or 2 with the macro defined.
- Single port sweep: port 0 holds req for addr 0..15 consecutively -> ack[0] every cycle; r_valid[0] each cycle from L; r_data[0] = 0x20..0x2F in order; other ports' r_valid stay 0 and r_data stays 0.
- All four ports request continuously from reset; port i steps its address after each ack -> ack sequence is 0,1,2,3,0,1,… (one-hot, never two bits high); each port receives exactly its own data stream.
- Wrap and pointer:
  - Port 3 is granted at addr 15, giving 0x2F after L.
  - Ports 0 and 2 then request together -> port 0 is granted first, since ptr wrapped to 0.
  - Ports 2 and 0 request together after a grant to port 1 -> port 2 is granted first.
- Hold behaviour: port 1 reads addr 5 (0x25), then stays idle 10 cycles while port 2 reads -> r_data[1] remains 0x25 and r_valid[1] stays low.
- Reset mid-operation:
  - Drive arst_n low for one cycle immediately after the grant edge -> no r_valid for that read; all r_data = 0; ptr = 0.
  - After release, ports 1 and 0 request together -> port 0 is granted first.
- Idle: req = 0 for 20 cycles -> ack = 0, r_valid = 0, r_data unchanged.
